// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   DATA_W / ADDR_W : register data width and register index width
//   wb_entry_t      : one pending register write {rd, data}; rd sits in the
//                     upper bits so a slice from the MSB end yields the index
//   is_zero_rd      : true for x0, which is never written, queued or hazarded
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_rd(input logic [ADDR_W-1:0] rd);
    return (rd == {ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer holding load returns that could not reach the write port.
// Ports:
//   clk, reset     : clock and synchronous active-low reset
//   push/push_data : enqueue at the tail (caller never pushes when full)
//   pop/head       : dequeue at the head (caller never pops when empty)
//   count          : occupancy, 0..DEPTH
//   full, empty    : occupancy flags derived from count
//   entries        : age-ordered view (slot 0 = oldest) of the top VIEW_W
//                    bits of every slot; slots at or beyond count are stale
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 37,
  parameter int VIEW_W = WIDTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic [PTR_W:0]          count,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH*VIEW_W-1:0] entries
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({push, pop})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so stale slots never carry X.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Age-ordered view rotated from the read pointer.
  always_comb begin
    entries = {(DEPTH*VIEW_W){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      entries[i*VIEW_W +: VIEW_W] = mem_r[rd_ptr_r + PTR_W'(i)][WIDTH-1 -: VIEW_W];
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == (PTR_W+1)'(DEPTH));
  assign empty = (count_r == {(PTR_W+1){1'b0}});

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage feeding the register file's single write port.
// Merges ALU results (always accepted, highest priority) with load returns;
// loads that lose arbitration wait in a DEPTH-entry FIFO. Decode is told to
// stall while any of its indices names a still-pending destination.
// Ports:
//   clk, reset                          : clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data           : ALU result
//   mem_valid/mem_ready/mem_rd/mem_data : load return handshake
//   dec_rs1/dec_rs2/dec_rd              : decode indices for hazard check
//   hazard                              : decode must stall (combinational)
//   register_d/data_register_d_in/write_register_d : registered write port
//   pending_count                       : FIFO occupancy
// Optional build macro WB_BYPASS_EN adds byp_rs{1,2}_{valid,data}: a pending
// source value is forwarded instead of stalling; only dec_rd still stalls.
// DATA_W/ADDR_W must match the wb_pkg constants that size wb_entry_t.
module writeback_stage #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  input  logic [ADDR_W-1:0] dec_rd,
  output logic              hazard,
  output logic [ADDR_W-1:0] register_d,
  output logic [DATA_W-1:0] data_register_d_in,
  output logic              write_register_d,
  output logic [CNT_W-1:0]  pending_count
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_rs1_valid,
  output logic [DATA_W-1:0] byp_rs1_data,
  output logic              byp_rs2_valid,
  output logic [DATA_W-1:0] byp_rs2_data
`endif
);

  import wb_pkg::*;

  localparam int ENTRY_W = $bits(wb_entry_t);
  // Hazard compare needs only rd; forwarding needs the whole entry.
`ifdef WB_BYPASS_EN
  localparam int VIEW_W = ENTRY_W;
`else
  localparam int VIEW_W = ADDR_W;
`endif

  wb_entry_t alu_entry_s;
  wb_entry_t mem_entry_s;
  wb_entry_t head_s;
  wb_entry_t sel_s;
  wb_entry_t out_r;
  logic      wr_r;
  logic      sel_wr_s;
  logic      push_s;
  logic      pop_s;
  logic      full_s;
  logic      empty_s;
  logic      mem_hs_s;
  logic      mem_keep_s;
  logic [CNT_W-1:0]          count_s;
  logic [DEPTH*VIEW_W-1:0]   view_s;
  logic [ADDR_W-1:0]         fifo_rd_s [DEPTH];
  logic [2:0][ADDR_W-1:0]    dec_idx_s;
  logic [2:0]                match_s;
`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0]         fifo_data_s [DEPTH];
  logic [2:0][DATA_W-1:0]    byp_data_s;
`endif

  assign alu_entry_s.rd   = alu_rd;
  assign alu_entry_s.data = alu_data;
  assign mem_entry_s.rd   = mem_rd;
  assign mem_entry_s.data = mem_data;

  // Readiness comes from registered occupancy only, never from a same-cycle pop.
  assign mem_ready  = ~full_s;
  assign mem_hs_s   = mem_valid & mem_ready;
  assign mem_keep_s = mem_hs_s & ~is_zero_rd(mem_rd);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .VIEW_W (VIEW_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (mem_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s),
    .entries   (view_s)
  );

  // Write-port arbitration: ALU, then FIFO head, then cut-through load.
  always_comb begin
    sel_s    = alu_entry_s;
    sel_wr_s = 1'b0;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    if (alu_valid) begin
      sel_s    = alu_entry_s;
      sel_wr_s = ~is_zero_rd(alu_rd);
      push_s   = mem_keep_s;
    end else if (!empty_s) begin
      // Queued entries never carry x0, so the head always writes.
      sel_s    = head_s;
      sel_wr_s = 1'b1;
      pop_s    = 1'b1;
      push_s   = mem_keep_s;
    end else if (mem_hs_s) begin
      sel_s    = mem_entry_s;
      sel_wr_s = ~is_zero_rd(mem_rd);
    end else begin
      sel_wr_s = 1'b0;
    end
  end

  // Registered write port; index/data only move when a write is issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_r       <= 1'b0;
      out_r.rd   <= {ADDR_W{1'b0}};
      out_r.data <= {DATA_W{1'b0}};
    end else begin
      wr_r <= sel_wr_s;
      if (sel_wr_s) out_r <= sel_s;
    end
  end

  assign write_register_d   = wr_r;
  assign register_d         = out_r.rd;
  assign data_register_d_in = out_r.data;
  assign pending_count      = count_s;

  // Unpack the FIFO's age-ordered view into per-slot fields.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef WB_BYPASS_EN
      fifo_rd_s[i]   = view_s[i*VIEW_W + DATA_W +: ADDR_W];
      fifo_data_s[i] = view_s[i*VIEW_W +: DATA_W];
`else
      fifo_rd_s[i]   = view_s[i*VIEW_W +: VIEW_W];
`endif
    end
  end

  assign dec_idx_s = {dec_rd, dec_rs2, dec_rs1};

  // Pending-destination match per decode index. The output stage is the
  // oldest pending write; later FIFO slots are younger and override it.
  always_comb begin
    logic hit_v;
    hit_v   = 1'b0;
    match_s = 3'b000;
`ifdef WB_BYPASS_EN
    byp_data_s = {(3*DATA_W){1'b0}};
`endif
    for (int s = 0; s < 3; s++) begin
      hit_v      = wr_r && (out_r.rd == dec_idx_s[s]);
      match_s[s] = hit_v;
`ifdef WB_BYPASS_EN
      byp_data_s[s] = hit_v ? out_r.data : {DATA_W{1'b0}};
`endif
      for (int i = 0; i < DEPTH; i++) begin
        hit_v      = (CNT_W'(i) < count_s) && (fifo_rd_s[i] == dec_idx_s[s]);
        match_s[s] = match_s[s] | hit_v;
`ifdef WB_BYPASS_EN
        byp_data_s[s] = hit_v ? fifo_data_s[i] : byp_data_s[s];
`endif
      end
      match_s[s] = match_s[s] & ~is_zero_rd(dec_idx_s[s]);
    end
  end

`ifdef WB_BYPASS_EN
  assign hazard        = match_s[2];
  assign byp_rs1_valid = match_s[0];
  assign byp_rs1_data  = byp_data_s[0];
  assign byp_rs2_valid = match_s[1];
  assign byp_rs2_data  = byp_data_s[1];
`else
  assign hazard = |match_s;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// random traffic, every cycle compared against a queue-based reference model.
module tb_writeback_stage;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;
  logic              hazard;
  logic [ADDR_W-1:0] register_d;
  logic [DATA_W-1:0] data_register_d_in;
  logic              write_register_d;
  logic [2:0]        pending_count;
`ifdef WB_BYPASS_EN
  logic              byp_rs1_valid, byp_rs2_valid;
  logic [DATA_W-1:0] byp_rs1_data, byp_rs2_data;
`endif

  always #5 clk = ~clk;

  writeback_stage #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard(hazard),
    .register_d(register_d), .data_register_d_in(data_register_d_in),
    .write_register_d(write_register_d), .pending_count(pending_count)
`ifdef WB_BYPASS_EN
    , .byp_rs1_valid(byp_rs1_valid), .byp_rs1_data(byp_rs1_data)
    , .byp_rs2_valid(byp_rs2_valid), .byp_rs2_data(byp_rs2_data)
`endif
  );

  // Reference model: pending loads in program order plus the write in flight.
  typedef struct { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; } ent_t;
  ent_t              q[$];
  logic              exp_wr   = 1'b0;
  logic [ADDR_W-1:0] exp_rd   = '0;
  logic [DATA_W-1:0] exp_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Is this register the destination of any write not yet in the regfile?
  function automatic bit pending(input logic [ADDR_W-1:0] idx);
    if (idx == 0) return 1'b0;
    if (exp_wr && exp_rd == idx) return 1'b1;
    foreach (q[i]) if (q[i].rd == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Value the register will finally hold once everything pending lands.
  function automatic bit youngest(input logic [ADDR_W-1:0] idx, output logic [DATA_W-1:0] val);
    bit found = 1'b0;
    val = '0;
    if (idx == 0) return 1'b0;
    if (exp_wr && exp_rd == idx) begin found = 1'b1; val = exp_data; end
    foreach (q[i]) if (q[i].rd == idx) begin found = 1'b1; val = q[i].data; end
    return found;
  endfunction

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rst_v, input logic av, input logic [ADDR_W-1:0] ard,
                      input logic [DATA_W-1:0] ad, input logic mv, input logic [ADDR_W-1:0] mrd,
                      input logic [DATA_W-1:0] md, input logic [ADDR_W-1:0] s1,
                      input logic [ADDR_W-1:0] s2, input logic [ADDR_W-1:0] d);
    bit   ready, hs;
    ent_t nxt;
    bit   nxt_wr;
`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] bv;
    bit                bf;
`endif
    @(negedge clk);
    reset = rst_v; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    dec_rs1 = s1; dec_rs2 = s2; dec_rd = d;
    #1;
    ready = (q.size() < DEPTH);
    check_value("mem_ready", mem_ready, ready);
    check_value("pending_count", pending_count, q.size());
    check_value("write_en", write_register_d, exp_wr);
    if (exp_wr) begin
      check_value("write_rd", register_d, exp_rd);
      check_value("write_data", data_register_d_in, exp_data);
    end
`ifdef WB_BYPASS_EN
    check_value("hazard", hazard, pending(d));
    bf = youngest(s1, bv);
    check_value("byp1_valid", byp_rs1_valid, bf);
    if (bf) check_value("byp1_data", byp_rs1_data, bv);
    bf = youngest(s2, bv);
    check_value("byp2_valid", byp_rs2_valid, bf);
    if (bf) check_value("byp2_data", byp_rs2_data, bv);
`else
    check_value("hazard", hazard, pending(s1) | pending(s2) | pending(d));
`endif
    hs = mv && ready;
    if (!rst_v) begin
      q.delete();
      exp_wr = 1'b0; exp_rd = '0; exp_data = '0;
    end else begin
      nxt_wr = 1'b0;
      nxt    = '{rd: exp_rd, data: exp_data};
      if (av) begin
        nxt_wr = (ard != 0);
        nxt    = '{rd: ard, data: ad};
      end else if (q.size() > 0) begin
        nxt    = q.pop_front();
        nxt_wr = 1'b1;
      end else if (hs) begin
        nxt_wr = (mrd != 0);
        nxt    = '{rd: mrd, data: md};
        hs     = 1'b0;  // consumed by cut-through
      end
      if (hs && mrd != 0) q.push_back('{rd: mrd, data: md});
      exp_wr = nxt_wr;
      if (nxt_wr) begin exp_rd = nxt.rd; exp_data = nxt.data; end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    dec_rs1 = 5'd3; dec_rs2 = 5'd0; dec_rd = 5'd0;
    repeat (2) @(posedge clk);
    #2;
    check_value("rst_write_en", write_register_d, 1'b0);
    check_value("rst_rd", register_d, 5'd0);
    check_value("rst_data", data_register_d_in, 32'd0);
    check_value("rst_count", pending_count, 3'd0);
    check_value("rst_ready", mem_ready, 1'b1);
    check_value("rst_hazard", hazard, 1'b0);

    // ALU only
    step(1, 1, 3, 32'h55, 0, 0, 0, 0, 0, 0);
    #2;
    check_value("alu_we", write_register_d, 1'b1);
    check_value("alu_rd", register_d, 5'd3);
    check_value("alu_data", data_register_d_in, 32'h55);
    idle(1);

    // Collision: ALU wins, load queued for one cycle
    step(1, 1, 4, 32'h11, 1, 5, 32'h22, 0, 0, 0);
    #2;
    check_value("coll_count1", pending_count, 3'd1);
    check_value("coll_rd4", register_d, 5'd4);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_value("coll_rd5", register_d, 5'd5);
    check_value("coll_data5", data_register_d_in, 32'h22);
    check_value("coll_count0", pending_count, 3'd0);
    idle(2);

    // Full FIFO: ALU holds the port while loads r6..r9 arrive
    for (int i = 0; i < DEPTH; i++)
      step(1, 1, 5'(20 + i), $urandom, 1, 5'(6 + i), 32'h100 + i, 0, 0, 0);
    #2;
    check_value("full_ready", mem_ready, 1'b0);
    check_value("full_count", pending_count, 3'd4);
    step(1, 1, 24, $urandom, 1, 10, 32'h10A, 0, 0, 0);  // 5th load stalls
    step(1, 0, 0, 0, 1, 10, 32'h10A, 0, 0, 0);          // pop, ready still low
    step(1, 0, 0, 0, 1, 10, 32'h10A, 0, 0, 0);          // pop + push
    idle(6);

    // Hazard on a queued load to r7, then x0 source alone
    step(1, 1, 11, 32'h1, 1, 7, 32'h77, 0, 7, 0);
    step(1, 1, 12, 32'h2, 0, 0, 0, 0, 7, 0);
    step(1, 1, 13, 32'h3, 0, 0, 0, 0, 7, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // x0 drops: cut-through and behind a busy ALU
    step(1, 0, 0, 0, 1, 0, 32'hFF, 0, 0, 0);
    #2;
    check_value("x0_we", write_register_d, 1'b0);
    check_value("x0_count", pending_count, 3'd0);
    step(1, 1, 14, 32'h4, 1, 0, 32'hFF, 0, 0, 0);
    idle(2);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++)
      step(1, 1, 5'(15 + i), $urandom, 1, 5'(25 + i), $urandom, 0, 0, 0);
    step(0, 1, 18, 32'h5, 1, 28, 32'h6, 0, 0, 0);
    #2;
    check_value("mid_rst_count", pending_count, 3'd0);
    check_value("mid_rst_we", write_register_d, 1'b0);
    check_value("mid_rst_ready", mem_ready, 1'b1);
    idle(4);

    // Queued r8 = 0xABCD read by decode
    step(1, 1, 19, 32'h7, 1, 8, 32'hABCD, 8, 0, 0);
    step(1, 1, 21, 32'h8, 0, 0, 0, 8, 0, 0);
    idle(3);

    // Random traffic over a narrow register range to provoke hazards
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Writeback stage directly upstream of the register file.
- Merges two result sources onto the register file's single write port (register_d / data_register_d_in / write_register_d):
  - ALU results;
  - load data returned by the cache after a hit or miss.
- Buffers load returns in a small FIFO while the ALU holds the port.
- Reports pending-destination hazards so decode stalls until queued writes have landed.

Parameters:
- DEPTH, 4: load-return FIFO entries; power of two, at least 2.
- DATA_W, 32: register data width.
- ADDR_W, 5: register index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; state clears on a clk edge while reset=0.
- alu_valid  in  1  ALU result valid this cycle; always accepted.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load return valid.
- mem_ready  out  1  load return accepted; transfer when mem_valid and mem_ready are both 1.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- dec_rs1  in  ADDR_W  decode source register 1.
- dec_rs2  in  ADDR_W  decode source register 2.
- dec_rd  in  ADDR_W  decode destination register.
- hazard  out  1  decode must stall.
- register_d  out  ADDR_W  write index to the register file.
- data_register_d_in  out  DATA_W  write data to the register file.
- write_register_d  out  1  write enable to the register file.
- pending_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: write_register_d=0, register_d=0, data_register_d_in=0, FIFO empty, pending_count=0, mem_ready=1, hazard=0.
- Write-port outputs are registered: a source selected in cycle N drives the register file during cycle N+1 and is written at the end of N+1.
- Selection each cycle, in priority order:
  1. alu_valid=1: the ALU result is selected.
  2. Otherwise, FIFO non-empty: the FIFO head is selected and popped.
  3. Otherwise, FIFO empty and a mem handshake: mem is selected directly (cut-through, no enqueue).
  4. Otherwise, write_register_d=0 next cycle.
- A mem handshake that is not selected is pushed to the FIFO tail. This includes alu_valid=1 with a mem handshake, and a mem handshake while the FIFO is non-empty.
- Simultaneous pop of the head and push of a new entry is legal: count is unchanged and the pointers wrap modulo DEPTH.
- mem_ready = (count < DEPTH), registered-state only; it is not raised early by a same-cycle pop.
- While mem_ready=0, mem_valid is ignored and the FIFO keeps its contents.
- rd = 0 from either source:
  - never written, never enqueued, never hazards;
  - write_register_d stays 0 for that slot;
  - the FIFO is still drained normally.
- hazard is combinational. It is 1 when any nonzero one of dec_rs1, dec_rs2 or dec_rd equals the rd of:
  - any valid FIFO entry, or
  - the output stage while write_register_d=1.
- The core guarantees that no ALU result targets a register with a pending load while hazard=1, which keeps the FIFO ordering equal to program order.
- Reset mid-operation: all FIFO entries are discarded, no partial write is issued, and write_register_d=0 in the cycle after the reset edge.

Optional Feature:
- WB_BYPASS_EN defined:
  - adds outputs byp_rs1_valid, byp_rs1_data, byp_rs2_valid, byp_rs2_data;
  - each source register is matched against the youngest match among the output stage and the FIFO entries;
  - a matched source returns the pending data, and hazard ignores that source;
  - hazard is still raised for a dec_rd match.
- WB_BYPASS_EN undefined: these ports are absent and hazard covers all three indices.

Decomposition:
- Shared package wb_pkg:
  - DATA_W and ADDR_W constants;
  - wb_entry_t struct {rd, data};
  - function is_zero_rd.
- One natural sub-module: wb_fifo. A parameterised circular buffer with push, pop, head, count, full and empty, plus a flattened entry-array output for hazard compare.
- Selection, the output register and hazard logic stay in writeback_stage.

Test Plan:
- ALU only: alu_valid=1, rd=3, data=0x55 in cycle 0 -> write_register_d=1, register_d=3, data=0x55 in cycle 1; regfile[3]=0x55 after cycle 1.
- Collision: alu(rd=4, 0x11) and mem(rd=5, 0x22) both in cycle 0 -> cycle 1 writes r4=0x11, cycle 2 writes r5=0x22; pending_count is 1 after cycle 0 and 0 after cycle 1.
- Full FIFO:
  - stimulus: alu_valid held 1 while DEPTH loads (rd 6..9) arrive;
  - response: mem_ready drops to 0 and a 5th load stalls;
  - release: alu_valid falls -> drain order is r6, r7, r8, r9 on consecutive cycles, then mem_ready=1.
- Hazard:
  - stimulus: load rd=7 queued, dec_rs2=7;
  - response: hazard=1 until the cycle after r7's write_register_d pulse, then 0;
  - rd=0 case: dec_rs1=0 alone -> hazard=0.
- x0 drop: mem(rd=0, 0xFF) -> no write pulse, pending_count stays 0.
- Reset mid-operation:
  - stimulus: 3 queued entries, reset=0 for one edge;
  - response: pending_count=0, write_register_d=0, mem_ready=1, and no stale write afterwards.
- Bypass (WB_BYPASS_EN defined): queued r8=0xABCD with dec_rs1=8 -> byp_rs1_valid=1, byp_rs1_data=0xABCD, hazard=0.
